// File: rtl/ge_add_seq.sv
// ge_add_seq: word-serial operand loader and result drainer for the ge_add core.
// Collects eight 320-bit operands as a 32-bit word stream (most-significant limb
// first), fires one ge_valid pulse, waits for ge_done, then streams r_x/r_y/r_z/r_t
// back out as 40 words. Operations never overlap.
// Optional build macro GE_ADD_SEQ_TIMEOUT_EN adds a WAIT watchdog that raises a
// sticky err and drains an all-zero result if ge_done never arrives.
module ge_add_seq #(
    parameter int WORD_W         = 32,
    parameter int LIMBS          = 10,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WORD_W-1:0]         in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WORD_W-1:0]         out_data,
    output logic                      busy,
    output logic                      err,
    output logic [WORD_W*LIMBS-1:0]   ge_p_x,
    output logic [WORD_W*LIMBS-1:0]   ge_p_y,
    output logic [WORD_W*LIMBS-1:0]   ge_p_z,
    output logic [WORD_W*LIMBS-1:0]   ge_p_t,
    output logic [WORD_W*LIMBS-1:0]   ge_q_yplusx,
    output logic [WORD_W*LIMBS-1:0]   ge_q_yminusx,
    output logic [WORD_W*LIMBS-1:0]   ge_q_t2d,
    output logic [WORD_W*LIMBS-1:0]   ge_q_z,
    output logic                      ge_valid,
    input  logic                      ge_done,
    input  logic [WORD_W*LIMBS-1:0]   ge_r_x,
    input  logic [WORD_W*LIMBS-1:0]   ge_r_y,
    input  logic [WORD_W*LIMBS-1:0]   ge_r_z,
    input  logic [WORD_W*LIMBS-1:0]   ge_r_t
);

    localparam int ELEM_W   = WORD_W * LIMBS;
    localparam int N_OPS    = 8;
    localparam int N_RES    = 4;
    localparam int OUT_WRDS = N_RES * LIMBS;

    // The limb counters and lane offsets below are sized for 32-bit words.
    if (WORD_W != 32 || LIMBS != 10 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("ge_add_seq: unsupported WORD_W/LIMBS/TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t state;

    // Operand element index (0..7) and limb index within it (0..9); together
    // they are the 0..79 load word count.
    logic [2:0] eidx;
    logic [3:0] lidx;

    // Result words already handed to the consumer (0..39).
    logic [5:0] ocnt;

    // Operand store, element 0 = p_x ... element 7 = q_z.
    logic [N_OPS-1:0][ELEM_W-1:0] op;

    // Result buffer {r_x, r_y, r_z, r_t}; the current out word sits at the top
    // and the buffer shifts up one word per accepted handshake.
    logic [N_RES*ELEM_W-1:0] res_buf;

    // Bit offset of the limb being written: limb 0 is the most-significant one.
    logic [8:0] wr_lsb;

    logic load_last;
    logic drain_last;
    logic timeout_hit;

    // Derived control decodes; all outputs depend only on registered state.
    always_comb begin
        wr_lsb     = 9'((LIMBS - 1 - int'(lidx)) * WORD_W);
        load_last  = (eidx == 3'(N_OPS - 1)) && (lidx == 4'(LIMBS - 1));
        drain_last = (ocnt == 6'(OUT_WRDS - 1));
        in_ready   = (state == S_LOAD);
        ge_valid   = (state == S_ISSUE);
        out_valid  = (state == S_DRAIN);
        busy       = !((state == S_LOAD) && (eidx == 3'd0) && (lidx == 4'd0));
    end

    assign out_data     = res_buf[N_RES*ELEM_W-1 -: WORD_W];

    assign ge_p_x       = op[0];
    assign ge_p_y       = op[1];
    assign ge_p_z       = op[2];
    assign ge_p_t       = op[3];
    assign ge_q_yplusx  = op[4];
    assign ge_q_yminusx = op[5];
    assign ge_q_t2d     = op[6];
    assign ge_q_z       = op[7];

`ifdef GE_ADD_SEQ_TIMEOUT_EN
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TCNT_W-1:0] tcnt;
    logic              err_q;

    assign timeout_hit = (state == S_WAIT) && !ge_done &&
                         (tcnt == TCNT_W'(TIMEOUT_CYCLES - 1));
    assign err         = err_q;

    // Watchdog: counts WAIT cycles from zero, latches a sticky error on expiry.
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt  <= '0;
            err_q <= 1'b0;
        end else begin
            if (state == S_ISSUE) begin
                tcnt <= '0;
            end else if (state == S_WAIT) begin
                tcnt <= tcnt + 1'b1;
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    // Sequencer FSM: load words, pulse ge_valid, wait for done, drain results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_LOAD;
            eidx    <= '0;
            lidx    <= '0;
            ocnt    <= '0;
            op      <= '0;
            res_buf <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (in_valid) begin
                        op[eidx][wr_lsb +: WORD_W] <= in_data;
                        if (lidx == 4'(LIMBS - 1)) begin
                            lidx <= '0;
                            eidx <= load_last ? 3'd0 : eidx + 3'd1;
                        end else begin
                            lidx <= lidx + 4'd1;
                        end
                        if (load_last) begin
                            state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (ge_done) begin
                        res_buf <= {ge_r_x, ge_r_y, ge_r_z, ge_r_t};
                        ocnt    <= '0;
                        state   <= S_DRAIN;
                    end else if (timeout_hit) begin
                        res_buf <= '0;
                        ocnt    <= '0;
                        state   <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        res_buf <= res_buf << WORD_W;
                        if (drain_last) begin
                            ocnt  <= '0;
                            state <= S_LOAD;
                        end else begin
                            ocnt <= ocnt + 6'd1;
                        end
                    end
                end
                default: begin
                    state <= S_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ge_add_seq.sv
// tb_ge_add_seq: directed/randomized bench for ge_add_seq with the ge_add core
// replaced by a bench-driven done/result stub.
module tb_ge_add_seq;

    localparam int EW = 320;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_data;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic          busy;
    logic          err;
    logic [EW-1:0] ge_p_x, ge_p_y, ge_p_z, ge_p_t;
    logic [EW-1:0] ge_q_yplusx, ge_q_yminusx, ge_q_t2d, ge_q_z;
    logic          ge_valid;
    logic          ge_done;
    logic [EW-1:0] ge_r_x, ge_r_y, ge_r_z, ge_r_t;

    ge_add_seq #(.WORD_W(32), .LIMBS(10), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .err(err),
        .ge_p_x(ge_p_x), .ge_p_y(ge_p_y), .ge_p_z(ge_p_z), .ge_p_t(ge_p_t),
        .ge_q_yplusx(ge_q_yplusx), .ge_q_yminusx(ge_q_yminusx),
        .ge_q_t2d(ge_q_t2d), .ge_q_z(ge_q_z),
        .ge_valid(ge_valid), .ge_done(ge_done),
        .ge_r_x(ge_r_x), .ge_r_y(ge_r_y), .ge_r_z(ge_r_z), .ge_r_t(ge_r_t)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int gv_cnt = 0;
    int gv_base;

    // Reference model state: the 80 words streamed in, the operands they must
    // form, and the four results the stub core returns.
    logic [31:0]   words [80];
    logic [EW-1:0] exp_op [8];
    logic [EW-1:0] exp_res [4];

    // Counts ge_valid pulses seen at rising edges.
    always @(posedge clk) if (ge_valid === 1'b1) gv_cnt <= gv_cnt + 1;

    task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [EW-1:0] rand320();
        logic [EW-1:0] v = '0;
        for (int i = 0; i < 10; i++) v = {v[EW-33:0], 32'($urandom)};
        return v;
    endfunction

    // Each operand is its ten words concatenated, first word most significant.
    task automatic build_ops();
        for (int e = 0; e < 8; e++) begin
            exp_op[e] = '0;
            for (int k = 0; k < 10; k++) exp_op[e] = {exp_op[e][EW-33:0], words[e*10+k]};
        end
    endtask

    task automatic garbage_results();
        ge_r_x = rand320(); ge_r_y = rand320(); ge_r_z = rand320(); ge_r_t = rand320();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; ge_done = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Streams words[0..79]; optional random idle gaps and a stray ge_done pulse.
    task automatic load_all(input bit gaps, input int spur_at);
        gv_base = gv_cnt;
        build_ops();
        for (int w = 0; w < 80; w++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0; in_data = $urandom; @(negedge clk);
                end
            end
            if (w == 1) chk("busy_mid_load", busy, 1);
            chk("in_ready_load", in_ready, 1);
            chk("ge_valid_load", ge_valid, 0);
            in_valid = 1'b1; in_data = words[w];
            ge_done = (w == spur_at);
            if (w == spur_at) garbage_results();
            @(negedge clk);
        end
        in_valid = 1'b0; ge_done = 1'b0; in_data = $urandom;
    endtask

    // Called in the ISSUE cycle; ends in the first DRAIN cycle.
    task automatic issue_wait(input bit spur_issue, input int wait_cycles);
        chk("ge_valid_issue", ge_valid, 1);
        chk("in_ready_issue", in_ready, 0);
        chk("busy_issue", busy, 1);
        if (spur_issue) begin ge_done = 1'b1; garbage_results(); end
        @(negedge clk);
        ge_done = 1'b0;
        chk("ge_valid_wait", ge_valid, 0);
        chk("out_valid_wait", out_valid, 0);
        chk("in_ready_wait", in_ready, 0);
        chk("op_p_x", ge_p_x, exp_op[0]);
        chk("op_p_y", ge_p_y, exp_op[1]);
        chk("op_p_z", ge_p_z, exp_op[2]);
        chk("op_p_t", ge_p_t, exp_op[3]);
        chk("op_q_yplusx", ge_q_yplusx, exp_op[4]);
        chk("op_q_yminusx", ge_q_yminusx, exp_op[5]);
        chk("op_q_t2d", ge_q_t2d, exp_op[6]);
        chk("op_q_z", ge_q_z, exp_op[7]);
        repeat (wait_cycles) begin
            @(negedge clk);
            chk("out_valid_waiting", out_valid, 0);
            chk("busy_waiting", busy, 1);
        end
        for (int i = 0; i < 4; i++) exp_res[i] = rand320();
        ge_r_x = exp_res[0]; ge_r_y = exp_res[1]; ge_r_z = exp_res[2]; ge_r_t = exp_res[3];
        ge_done = 1'b1;
        @(negedge clk);
        ge_done = 1'b0;
        garbage_results();
        chk("out_valid_after_done", out_valid, 1);
        chk("op_hold_p_x", ge_p_x, exp_op[0]);
    endtask

    // Drains 40 words, optionally stalling out_ready for stall_len cycles.
    task automatic drain(input int stall_at, input int stall_len);
        logic [31:0] ew [40];
        logic [EW-1:0] t;
        for (int e = 0; e < 4; e++) begin
            t = exp_res[e];
            for (int k = 0; k < 10; k++) begin
                ew[e*10+k] = t[EW-1 -: 32];
                t = t << 32;
            end
        end
        for (int i = 0; i < 40; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    out_ready = 1'b0;
                    @(negedge clk);
                    chk("stall_out_valid", out_valid, 1);
                    chk("stall_out_data", out_data, ew[i]);
                end
            end
            out_ready = 1'b1;
            chk("drain_out_valid", out_valid, 1);
            chk($sformatf("drain_word_%0d", i), out_data, ew[i]);
            chk("drain_in_ready", in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk("end_out_valid", out_valid, 0);
        chk("end_in_ready", in_ready, 1);
        chk("end_busy", busy, 0);
        chk("ge_valid_once", gv_cnt - gv_base, 1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; ge_done = 1'b0;
        garbage_results();

        // Reset state.
        do_reset();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_ge_valid", ge_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_p_x", ge_p_x, 0);
        chk("rst_q_z", ge_q_z, 0);

        // Word ordering: word n carries value n.
        for (int w = 0; w < 80; w++) words[w] = 32'(w);
        load_all(1'b0, -1);
        chk("ord_p_x_top", ge_p_x[319:288], 32'h0);
        chk("ord_p_x_low", ge_p_x[31:0], 32'h9);
        chk("ord_q_z_low", ge_q_z[31:0], 32'h4f);
        chk("ord_p_y_top", ge_p_y[319:288], 32'ha);
        issue_wait(1'b0, 3);
        drain(-1, 0);

        // Backpressure on both sides with random data.
        for (int w = 0; w < 80; w++) words[w] = $urandom;
        load_all(1'b1, -1);
        issue_wait(1'b0, $urandom_range(0, 8));
        drain(17, 5);

        // Spurious done in LOAD and in ISSUE.
        for (int w = 0; w < 80; w++) words[w] = $urandom;
        load_all(1'b0, 33);
        issue_wait(1'b1, 2);
        drain(-1, 0);

        // Reset while waiting, then a late done.
        for (int w = 0; w < 80; w++) words[w] = $urandom;
        load_all(1'b0, -1);
        chk("pre_rst_ge_valid", ge_valid, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; ge_done = 1'b1; garbage_results();
        @(negedge clk);
        ge_done = 1'b0;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_p_x", ge_p_x, 0);
        @(negedge clk);
        chk("midrst_out_valid2", out_valid, 0);

        // A normal operation after the abort.
        for (int w = 0; w < 80; w++) words[w] = $urandom;
        load_all(1'b1, -1);
        issue_wait(1'b0, 1);
        drain(3, 2);
        chk("final_err", err, 0);

`ifdef GE_ADD_SEQ_TIMEOUT_EN
        // Watchdog: no done ever arrives.
        for (int w = 0; w < 80; w++) words[w] = $urandom;
        load_all(1'b0, -1);
        @(negedge clk);
        chk("to_err_start", err, 0);
        repeat (15) begin
            @(negedge clk);
            chk("to_err_early", err, 0);
            chk("to_out_valid_early", out_valid, 0);
        end
        @(negedge clk);
        chk("to_err_set", err, 1);
        chk("to_out_valid", out_valid, 1);
        for (int i = 0; i < 4; i++) exp_res[i] = '0;
        drain(-1, 0);
        chk("to_err_sticky", err, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
